// File: rtl/pulsador_up_down_pkg.sv
// Shared definitions for the push-button conditioner:
// pulse FSM state codes and a counter sizing helper.
package pulsador_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pulsador_up_down_if.sv
// One button channel: raw button level in, pulse request out.
// master drives btn and observes req; slave is the conditioner.
interface pulsador_up_down_if;
  logic btn;
  logic req;

  modport master (output btn, input req);
  modport slave  (input btn, output req);
endinterface

// File: rtl/pulsador_up_down_canal.sv
// One button channel: 2-flop synchronizer, debounce filter and
// pulse/auto-repeat FSM. Ports: clk, rst_n, ch (btn in, req out).
module canal_pulsador
  import pulsador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input logic               clk,
  input logic               rst_n,
  pulsador_up_down_if.slave ch
);

  localparam int DW = clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = clog2(TMAX);

  logic          meta_q, sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic          req;

  assign ch.req = req;

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive
  // mismatching edge, i.e. when the count reaches the limit.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    req     = 1'b0;
    if (!deb_q) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          req     = 1'b1;
          state_d = HOLD;
          tmr_d   = '0;
        end
        (state_q == HOLD): begin
          if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
            req     = 1'b1;
            state_d = REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        (state_q == REPEAT): begin
          if (tmr_q == TW'(REPEAT_CYCLES - 1)) begin
            req   = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      meta_q  <= ch.btn;
      sync_q  <= meta_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: rtl/pulsador_up_down.sv
// Two conditioned buttons feeding a mutually exclusive,
// registered enUP/enDOWN pair for the up/down counter.
module pulsador_up_down
  import pulsador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic enUP,
  output logic enDOWN
);

  pulsador_up_down_if up_if ();
  pulsador_up_down_if dn_if ();

  assign up_if.btn = btn_up;
  assign dn_if.btn = btn_down;

  canal_pulsador #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_up (
    .clk  (clk),
    .rst_n(reset),
    .ch   (up_if)
  );

  canal_pulsador #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_dn (
    .clk  (clk),
    .rst_n(reset),
    .ch   (dn_if)
  );

  logic en_up_q, en_up_d;
  logic en_dn_q, en_dn_d;

  // Coincident requests cancel each other; nothing is retried.
  always_comb begin
    en_up_d = up_if.req & ~dn_if.req;
    en_dn_d = dn_if.req & ~up_if.req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_up_q <= 1'b0;
      en_dn_q <= 1'b0;
    end else begin
      en_up_q <= en_up_d;
      en_dn_q <= en_dn_d;
    end
  end

  assign enUP   = en_up_q;
  assign enDOWN = en_dn_q;

endmodule

// File: tb/tb_pulsador_up_down.sv
// Directed bench for pulsador_up_down with a cycle-level
// behavioural model and literal pulse-time lists per scenario.
module tb_pulsador_up_down;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pulsador_up_down_if if_up ();
  pulsador_up_down_if if_dn ();

  always #5 clk = ~clk;

  pulsador_up_down #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .btn_up  (if_up.btn),
    .btn_down(if_dn.btn),
    .enUP    (if_up.req),
    .enDOWN  (if_dn.req)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;
  bit cap     = 1'b0;
  int got_u[$];
  int got_d[$];
  bit wu[$];
  bit wd[$];

  // Model: each button is a delayed, filtered level; a press
  // of age k (cycles since the filtered level rose) requests
  // a pulse at k = 0, k = HOLD and every REP after that.
  bit m_s1[2], m_s2[2], m_deb[2];
  int m_cnt[2], m_k[2];
  bit m_r[2], m_b[2];
  bit m_eu, m_ed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0;
        m_cnt[c] = 0; m_k[c] = 0;
      end
      m_eu = 0; m_ed = 0;
    end else begin
      m_b[0] = if_up.btn;
      m_b[1] = if_dn.btn;
      for (int c = 0; c < 2; c++) begin
        m_r[c] = m_deb[c] &&
          (m_k[c] == 0 || m_k[c] == HOLD ||
           (m_k[c] > HOLD && (m_k[c] - HOLD) % REP == 0));
        m_k[c] = m_deb[c] ? m_k[c] + 1 : 0;
        if (m_s2[c] != m_deb[c]) begin
          m_cnt[c]++;
          if (m_cnt[c] == DEB) begin
            m_deb[c] = m_s2[c];
            m_cnt[c] = 0;
          end
        end else begin
          m_cnt[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = m_b[c];
      end
      m_eu = m_r[0] & ~m_r[1];
      m_ed = m_r[1] & ~m_r[0];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit eu, ed;
    eu = rst_n ? m_eu : 1'b0;
    ed = rst_n ? m_ed : 1'b0;
    n_tests++;
    if (if_up.req !== eu || if_dn.req !== ed) begin
      n_fail++;
      $display("FAIL model cyc=%0d enUP=%b enDOWN=%b want %b %b",
               cyc, if_up.req, if_dn.req, eu, ed);
    end
    if (if_up.req === 1'b1 && if_dn.req === 1'b1) begin
      n_fail++;
      $display("FAIL excl cyc=%0d both enables high", cyc);
    end
    if (cap) begin
      if (if_up.req === 1'b1) got_u.push_back(cyc - base);
      if (if_dn.req === 1'b1) got_d.push_back(cyc - base);
    end
  end

  function automatic bit qeq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  task automatic chk_q(input string nm, input int g[$],
                       input int e[$]);
    n_tests++;
    if (!qeq(g, e)) begin
      n_fail++;
      $display("FAIL %s pulses got %p want %p", nm, g, e);
    end
  endtask

  task automatic chk_bit(input string nm, input logic g,
                         input logic e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s got %b want %b", nm, g, e);
    end
  endtask

  task automatic run(input string nm, input int total,
                     input int rst_at, input int rst_rel,
                     input int eu[$], input int ed[$]);
    base = cyc;
    got_u.delete();
    got_d.delete();
    cap = 1'b1;
    for (int c = 0; c < total; c++) begin
      if_up.btn = (c < wu.size()) ? wu[c] : 1'b0;
      if_dn.btn = (c < wd.size()) ? wd[c] : 1'b0;
      if (c == rst_rel) rst_n = 1'b1;
      if (c == rst_at) begin
        #2;
        chk_bit({nm, "_pre_rst_up"}, if_up.req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit({nm, "_async_up"}, if_up.req, 1'b0);
        chk_bit({nm, "_async_dn"}, if_dn.req, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    cap = 1'b0;
    chk_q({nm, "_up"}, got_u, eu);
    chk_q({nm, "_dn"}, got_d, ed);
  endtask

  task automatic wave_on(input bit up, input int n);
    if (up) begin
      wu.delete();
      for (int c = 0; c < n; c++) wu.push_back(1'b1);
    end else begin
      wd.delete();
      for (int c = 0; c < n; c++) wd.push_back(1'b1);
    end
  endtask

  int none[$];
  int e1[$];

  initial begin
    if_up.btn = 1'b0;
    if_dn.btn = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_up", if_up.req, 1'b0);
    chk_bit("reset_dn", if_dn.req, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    wave_on(1, 15); wd.delete();
    e1 = {7};
    run("clean", 30, -1, -1, e1, none);

    wu.delete(); wd.delete();
    for (int c = 0; c < 12; c++) wd.push_back(((c / 2) % 2) == 0);
    for (int c = 12; c < 25; c++) wd.push_back(1'b1);
    e1 = {19};
    run("bounce", 45, -1, -1, none, e1);

    wave_on(1, 60); wd.delete();
    e1 = {7, 27, 35, 43, 51, 59};
    run("repeat", 85, -1, -1, e1, none);

    wave_on(1, 60); wave_on(0, 30);
    e1 = {43, 51, 59};
    run("simul", 85, -1, -1, e1, none);

    wave_on(1, 76); wd.delete();
    e1 = {7, 27, 35, 55, 75};
    run("reset_mid", 105, 43, 48, e1, none);

    wave_on(1, 3); wd.delete();
    run("glitch", 20, -1, -1, none, none);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
